// File: rtl/dibit_serializer_pkg.sv
// dibit_serializer_pkg: shared definitions for the dibit serializer and the
// Acq_hold receiver that consumes its stream.
// FSM state codes, the 2 kHz bit-period constant, the counter width and the
// bit-ordering helpers live here, so that both ends agree on them.
// Optional feature macro used by the importing files: DIBIT_SER_SYNC_EN.
package dibit_serializer_pkg;

    // A two-bit symbol as carried on the parallel side.
    typedef logic [1:0] dibit_t;

    // FSM state encoding. These are kept as plain constants because existing
    // consumers compare raw state codes.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;

    // Clock cycles per bit for a 50 MHz clock and a 2 kHz bit rate.
    localparam int BIT_DIV_2KHZ = 25000;

    // Width of the per-bit cycle counter; BIT_DIV must fit in it.
    localparam int CNT_W = 16;

    // Bit of a symbol that goes out first on the serial line.
    function automatic logic lead_bit(input dibit_t sym, input bit msb_first);
        return msb_first ? sym[1] : sym[0];
    endfunction

    // Shift a symbol so the bit that goes out next sits in the lead position.
    function automatic dibit_t advance(input dibit_t sym, input bit msb_first);
        return msb_first ? {sym[0], 1'b0} : {1'b0, sym[1]};
    endfunction

endpackage

// File: rtl/dibit_serializer_if.sv
// dibit_serializer_if: symbol handshake and serial output bundle.
// The master side is the upstream symbol source (drives in/load, observes
// ready and the serial side); the slave side is the serializer itself.
// With DIBIT_SER_SYNC_EN defined the bundle also carries the sync pulse.
interface dibit_serializer_if;
    import dibit_serializer_pkg::*;

    dibit_t in;      // symbol to send, sampled only on accept
    logic   load;    // symbol valid strobe from upstream
    logic   ready;   // serializer can take a symbol this cycle
    logic   out;     // serial bit stream
    logic   busy;    // a symbol is being shifted out
`ifdef DIBIT_SER_SYNC_EN
    logic   sync;    // one-cycle marker on the first cycle of each symbol
`endif

`ifdef DIBIT_SER_SYNC_EN
    modport master (
        output in,
        output load,
        input  ready,
        input  out,
        input  busy,
        input  sync
    );

    modport slave (
        input  in,
        input  load,
        output ready,
        output out,
        output busy,
        output sync
    );
`else
    modport master (
        output in,
        output load,
        input  ready,
        input  out,
        input  busy
    );

    modport slave (
        input  in,
        input  load,
        output ready,
        output out,
        output busy
    );
`endif

endinterface

// File: rtl/dibit_serializer_bit_timer.sv
// bit_timer: counts clock cycles within one serial bit period.
// The count runs 0..BIT_DIV-1 while enabled and wraps to 0 after the terminal
// value, so it never exceeds BIT_DIV-1. tc flags the last cycle of a bit.
// A clear restarts the period (used when a new symbol is accepted).
module bit_timer
    import dibit_serializer_pkg::*;
#(
    parameter int BIT_DIV = BIT_DIV_2KHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

    // Reject divider values the 16-bit counter or the two-state bit timing
    // cannot represent.
    generate
        if (BIT_DIV < 2 || BIT_DIV > 65535) begin : g_bad_div
            $error("bit_timer: BIT_DIV out of range 2..65535");
        end
    endgenerate

    logic [CNT_W-1:0] count;

    // Cycle counter: restart on clear, wrap at the terminal value while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign tc = run && (count == LAST);

endmodule

// File: rtl/dibit_serializer.sv
// dibit_serializer: sends each accepted 2-bit symbol as two serial bits,
// each held for BIT_DIV clock cycles. A new symbol can be accepted on the
// last cycle of the second bit, giving a gapless stream.
// Parameters: BIT_DIV (cycles per bit), MSB_FIRST (1: in[1] goes first).
// Optional feature: define DIBIT_SER_SYNC_EN to add the sync output, a
// one-cycle pulse when the first bit of each new symbol appears on out.
module dibit_serializer
    import dibit_serializer_pkg::*;
#(
    parameter int BIT_DIV   = BIT_DIV_2KHZ,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    dibit_serializer_if.slave    bus
);

    logic [1:0] state;
    logic [1:0] state_next;
    dibit_t     shreg;
    logic       out_q;
    logic       tc;
    logic       ready_c;
    logic       accept;
    logic       running;

    // The block takes a symbol when idle, or on the final cycle of the
    // second bit so the next symbol follows without an idle cycle.
    assign running = (state != ST_IDLE);
    assign ready_c = (state == ST_IDLE) || ((state == ST_SECOND) && tc);
    assign accept  = bus.load && ready_c;

    bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .run   (running),
        .tc    (tc)
    );

    // Next-state logic: IDLE -> FIRST -> SECOND -> (FIRST | IDLE).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (tc) begin
                    state_next = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (tc) begin
                    state_next = accept ? ST_FIRST : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset wins over any simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register and registered output bit: load the symbol and present
    // its lead bit on accept, advance to the second bit at the end of FIRST.
    // Outside those events out keeps the last transmitted bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= 2'b00;
            out_q <= 1'b0;
        end else if (accept) begin
            shreg <= bus.in;
            out_q <= lead_bit(bus.in, MSB_FIRST);
        end else if ((state == ST_FIRST) && tc) begin
            shreg <= advance(shreg, MSB_FIRST);
            out_q <= lead_bit(advance(shreg, MSB_FIRST), MSB_FIRST);
        end
    end

    assign bus.out   = out_q;
    assign bus.busy  = running;
    assign bus.ready = ready_c;

`ifdef DIBIT_SER_SYNC_EN
    logic sync_q;

    // The first bit of a symbol appears the cycle after accept, so the
    // marker is simply the accept strobe delayed by one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= accept;
        end
    end

    assign bus.sync = sync_q;
`endif

endmodule

// File: doc/dibit_serializer.md
DIBIT_SERIALIZER -- requirements
Module: dibit_serializer

Interface
REQ-001 Parameter BIT_DIV, default 25000, clk cycles per output bit (50 MHz / 2 kHz); legal range 2..65535.
REQ-002 Parameter MSB_FIRST, default 1; 1 = in[1] sent first, 0 = in[0] sent first.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in  input  2  dibit symbol to serialize; sampled only on accept.
REQ-006 Port load  input  1  symbol valid strobe from upstream.
REQ-007 Port ready  output  1  block can accept a symbol this cycle.
REQ-008 Port out  output  1  serial bit stream, each bit held BIT_DIV cycles.
REQ-009 Port busy  output  1  high while a symbol is being shifted out.

Function
REQ-010 Accept occurs on a rising edge where load=1 and ready=1; in is captured into a 2-bit shift register at that edge.
REQ-011 FSM states: IDLE, FIRST, SECOND; IDLE->FIRST on accept; FIRST->SECOND when bit counter reaches BIT_DIV-1; SECOND->FIRST on accept in its final cycle, else SECOND->IDLE.
REQ-012 Bit counter 16 bits, cleared on accept and on each FIRST->SECOND transition, increments every cycle in FIRST/SECOND, never exceeds BIT_DIV-1.
REQ-013 out registered: first bit valid on the cycle after accept, held exactly BIT_DIV cycles, then second bit held exactly BIT_DIV cycles.
REQ-014 ready=1 in IDLE and in the last cycle of SECOND (counter=BIT_DIV-1); 0 otherwise.
REQ-015 Back-to-back accept in last SECOND cycle produces a gapless stream: next first bit follows immediately, no idle cycle.
REQ-016 load while ready=0 is ignored; the symbol is not queued and in is not sampled.
REQ-017 In IDLE, out holds the last transmitted bit (0 after reset); busy=0.
REQ-018 busy=1 in FIRST and SECOND, including the final cycle of SECOND.
REQ-019 Round-trip rule: a dibit stream produced at 2 kHz symbol-half rate and fed to the team's Acq_hold block reproduces the original pairs in order.

Reset
REQ-020 rst=1 at a rising edge forces IDLE, counter=0, shift register=00, out=0, busy=0, and ready=1 on the next cycle.
REQ-021 rst asserted mid-symbol aborts the symbol; no remaining bit is emitted.
REQ-022 rst takes priority over a simultaneous load; that symbol is dropped.

Configuration
REQ-023 Macro DIBIT_SER_SYNC_EN, when defined, adds output port sync (1 bit): a one-cycle pulse on the first cycle each new symbol's first bit appears on out.
REQ-024 Without DIBIT_SER_SYNC_EN the sync port and its logic do not exist; all other behaviour is identical.
REQ-025 sync resets to 0 and is 0 in IDLE.

Structure
REQ-026 Shared package holds FSM state encoding (IDLE=2'd0, FIRST=2'd1, SECOND=2'd2) and constant BIT_DIV_2KHZ=25000; the package is also used by Acq_hold.
REQ-027 Sub-module bit_timer (counter plus terminal-count flag, parameter BIT_DIV) is instantiated once; FSM and shift register remain in dibit_serializer.

Verification (BIT_DIV=4 for speed, one run at 25000)
REQ-028 Reset: rst high 3 cycles -> out=0, busy=0, ready=1; sync=0 if enabled.
REQ-029 Single symbol: in=2'b10, load 1 cycle in IDLE -> out=1 for 4 cycles, then 0 for 4 cycles, then busy=0; MSB_FIRST=0 gives 0 then 1.
REQ-030 Back-to-back: 10, 01, 11 each loaded when ready=1 -> out 1,0,0,1,1,1 each 4 cycles, no gaps; busy stays 1 throughout; sync pulses 3 times.
REQ-031 Ignored load: load=1 held with in=2'b00 during a 2'b11 symbol -> 11 sent intact, 00 accepted only at the ready cycle.
REQ-032 Abort: rst at cycle 2 of second bit -> out=0 next cycle, busy=0, no further bits.
REQ-033 Loopback: 64 random dibits, BIT_DIV=25000, into Acq_hold -> Acq_hold out matches the sent sequence.
